// File: rtl/datapath.sv
// datapath: 32-bit single-bus CPU datapath (R0-R15, HI, LO, PC, IR, MAR, MDR, Y, Z, Inport, C) with ALU.
// Optional macro DATAPATH_MULDIV_EN adds the signed multiplier (01110) and divider (01111).
`default_nettype none

module datapath (
    input  logic        Clock,
    input  logic        clear,
    input  logic        Read,
    input  logic        IncPC,
    input  logic [4:0]  opcode,
    input  logic        R0in,
    input  logic        R1in,
    input  logic        R2in,
    input  logic        R3in,
    input  logic        R4in,
    input  logic        R5in,
    input  logic        R6in,
    input  logic        R7in,
    input  logic        R8in,
    input  logic        R9in,
    input  logic        R10in,
    input  logic        R11in,
    input  logic        R12in,
    input  logic        R13in,
    input  logic        R14in,
    input  logic        R15in,
    input  logic        HIin,
    input  logic        LOin,
    input  logic        Yin,
    input  logic        Zin,
    input  logic        PCin,
    input  logic        IRin,
    input  logic        MARin,
    input  logic        MDRin,
    input  logic        Inportin,
    input  logic        Cin,
    input  logic        R0out,
    input  logic        R1out,
    input  logic        R2out,
    input  logic        R3out,
    input  logic        R4out,
    input  logic        R5out,
    input  logic        R6out,
    input  logic        R7out,
    input  logic        R8out,
    input  logic        R9out,
    input  logic        R10out,
    input  logic        R11out,
    input  logic        R12out,
    input  logic        R13out,
    input  logic        R14out,
    input  logic        R15out,
    input  logic        HIout,
    input  logic        LOout,
    input  logic        Yout,
    input  logic        Zhighout,
    input  logic        Zlowout,
    input  logic        PCout,
    input  logic        IRout,
    input  logic        MARout,
    input  logic        MDRout,
    input  logic        Inportout,
    input  logic        Cout,
    input  logic [31:0] Mdatain,
    output logic [31:0] BusMuxOut
);

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_NEG  = 5'b10000;
    localparam logic [4:0] OP_NOT  = 5'b10001;

    logic [15:0] rin;
    logic [15:0] rout;
    logic [31:0] bus;

    logic [31:0] rf_q [16];
    logic [31:0] rf_d [16];
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] y_q, y_d;
    logic [63:0] z_q, z_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] mar_q, mar_d;
    logic [31:0] mdr_q, mdr_d;
    logic [31:0] inport_q, inport_d;
    logic [31:0] c_q, c_d;

    logic [63:0] alu_res;
    logic [4:0]  shamt;
    logic [5:0]  shamt_inv;
    logic [31:0] shra_res;

    assign rin  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                   R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in};
    assign rout = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                   R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};

    // Lowest-numbered register wins, then the special registers in fixed order.
    always_comb begin
        bus = '0;
        if (|rout) begin
            for (int i = 15; i >= 0; i--) begin
                if (rout[i]) bus = rf_q[i];
            end
        end
        else if (HIout)     bus = hi_q;
        else if (LOout)     bus = lo_q;
        else if (Yout)      bus = y_q;
        else if (Zhighout)  bus = z_q[63:32];
        else if (Zlowout)   bus = z_q[31:0];
        else if (PCout)     bus = pc_q;
        else if (IRout)     bus = ir_q;
        else if (MARout)    bus = mar_q;
        else if (MDRout)    bus = mdr_q;
        else if (Inportout) bus = inport_q;
        else if (Cout)      bus = c_q;
    end

    assign BusMuxOut = bus;

    assign shamt     = bus[4:0];
    assign shamt_inv = 6'd32 - {1'b0, shamt};
    assign shra_res  = 32'($signed(y_q) >>> shamt);

`ifdef DATAPATH_MULDIV_EN
    logic [63:0]        mul_a;
    logic [63:0]        mul_b;
    logic [63:0]        mul_res;
    logic signed [31:0] div_q;
    logic signed [31:0] div_r;

    // Sign-extend both operands so the low 64 bits of the product are the signed result.
    assign mul_a   = {{32{y_q[31]}}, y_q};
    assign mul_b   = {{32{bus[31]}}, bus};
    assign mul_res = 64'($signed(mul_a) * $signed(mul_b));
    assign div_q   = (bus == 32'd0) ? 32'sd0 : $signed(y_q) / $signed(bus);
    assign div_r   = (bus == 32'd0) ? 32'sd0 : $signed(y_q) % $signed(bus);
`endif

    always_comb begin
        alu_res = '0;
        if (IncPC) begin
            alu_res = {32'd0, bus + 32'd1};
        end
        else begin
            case (opcode)
                OP_ADD:  alu_res = {32'd0, y_q + bus};
                OP_SUB:  alu_res = {32'd0, y_q - bus};
                OP_AND:  alu_res = {32'd0, y_q & bus};
                OP_OR:   alu_res = {32'd0, y_q | bus};
                OP_SHR:  alu_res = {32'd0, y_q >> shamt};
                OP_SHRA: alu_res = {32'd0, shra_res};
                OP_SHL:  alu_res = {32'd0, y_q << shamt};
                // A shift by 32 yields zero, so a zero rotate amount falls out naturally.
                OP_ROR:  alu_res = {32'd0, (y_q >> shamt) | (y_q << shamt_inv)};
                OP_ROL:  alu_res = {32'd0, (y_q << shamt) | (y_q >> shamt_inv)};
                OP_NEG:  alu_res = {32'd0, 32'd0 - bus};
                OP_NOT:  alu_res = {32'd0, ~bus};
`ifdef DATAPATH_MULDIV_EN
                OP_MUL:  alu_res = mul_res;
                OP_DIV:  alu_res = {div_r, div_q};
`endif
                default: alu_res = '0;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            rf_d[i] = rin[i] ? bus : rf_q[i];
        end
        hi_d     = HIin     ? bus : hi_q;
        lo_d     = LOin     ? bus : lo_q;
        y_d      = Yin      ? bus : y_q;
        z_d      = Zin      ? alu_res : z_q;
        pc_d     = PCin     ? bus : pc_q;
        ir_d     = IRin     ? bus : ir_q;
        mar_d    = MARin    ? bus : mar_q;
        mdr_d    = MDRin    ? (Read ? Mdatain : bus) : mdr_q;
        inport_d = Inportin ? bus : inport_q;
        c_d      = Cin      ? {{13{ir_q[18]}}, ir_q[18:0]} : c_q;
    end

    always_ff @(posedge Clock or posedge clear) begin
        if (clear) begin
            for (int i = 0; i < 16; i++) begin
                rf_q[i] <= '0;
            end
            hi_q     <= '0;
            lo_q     <= '0;
            y_q      <= '0;
            z_q      <= '0;
            pc_q     <= '0;
            ir_q     <= '0;
            mar_q    <= '0;
            mdr_q    <= '0;
            inport_q <= '0;
            c_q      <= '0;
        end
        else begin
            for (int i = 0; i < 16; i++) begin
                rf_q[i] <= rf_d[i];
            end
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            y_q      <= y_d;
            z_q      <= z_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            mar_q    <= mar_d;
            mdr_q    <= mdr_d;
            inport_q <= inport_d;
            c_q      <= c_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_datapath.sv
// tb_datapath: vector table, directed sequences and randomized traffic against a behavioural model.
`default_nettype none

module tb_datapath;

`ifdef DATAPATH_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    logic        Clock = 1'b0;
    logic        clear;
    logic        Read, IncPC;
    logic [4:0]  opcode;
    logic [15:0] rin, rout;
    logic        HIin, LOin, Yin, Zin, PCin, IRin, MARin, MDRin, Inportin, Cin;
    logic        HIout, LOout, Yout, Zhighout, Zlowout, PCout, IRout, MARout, MDRout, Inportout, Cout;
    logic [31:0] Mdatain;
    logic [31:0] BusMuxOut;

    int checks = 0;
    int errors = 0;

    always #5 Clock = ~Clock;

    datapath dut (
        .Clock(Clock), .clear(clear), .Read(Read), .IncPC(IncPC), .opcode(opcode),
        .R0in(rin[0]), .R1in(rin[1]), .R2in(rin[2]), .R3in(rin[3]),
        .R4in(rin[4]), .R5in(rin[5]), .R6in(rin[6]), .R7in(rin[7]),
        .R8in(rin[8]), .R9in(rin[9]), .R10in(rin[10]), .R11in(rin[11]),
        .R12in(rin[12]), .R13in(rin[13]), .R14in(rin[14]), .R15in(rin[15]),
        .HIin(HIin), .LOin(LOin), .Yin(Yin), .Zin(Zin), .PCin(PCin), .IRin(IRin),
        .MARin(MARin), .MDRin(MDRin), .Inportin(Inportin), .Cin(Cin),
        .R0out(rout[0]), .R1out(rout[1]), .R2out(rout[2]), .R3out(rout[3]),
        .R4out(rout[4]), .R5out(rout[5]), .R6out(rout[6]), .R7out(rout[7]),
        .R8out(rout[8]), .R9out(rout[9]), .R10out(rout[10]), .R11out(rout[11]),
        .R12out(rout[12]), .R13out(rout[13]), .R14out(rout[14]), .R15out(rout[15]),
        .HIout(HIout), .LOout(LOout), .Yout(Yout), .Zhighout(Zhighout), .Zlowout(Zlowout),
        .PCout(PCout), .IRout(IRout), .MARout(MARout), .MDRout(MDRout),
        .Inportout(Inportout), .Cout(Cout),
        .Mdatain(Mdatain), .BusMuxOut(BusMuxOut)
    );

    typedef struct {
        logic [4:0]  op;
        logic        inc;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] z_base;
        logic [63:0] z_md;
    } vec_t;

    vec_t vt [19];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic clr_strobes();
        rin = '0; rout = '0; Read = 0; IncPC = 0; opcode = '0;
        {HIin, LOin, Yin, Zin, PCin, IRin, MARin, MDRin, Inportin, Cin} = '0;
        {HIout, LOout, Yout, Zhighout, Zlowout, PCout, IRout, MARout, MDRout, Inportout, Cout} = '0;
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
        clr_strobes();
    endtask

    task automatic load_mdr(input logic [31:0] v);
        Mdatain = v; Read = 1; MDRin = 1;
        step();
    endtask

    task automatic read_r(input int i, output logic [31:0] v);
        rout[i] = 1'b1; #1; v = BusMuxOut; rout[i] = 1'b0;
    endtask

    task automatic read_z(output logic [63:0] z);
        Zhighout = 1; #1; z[63:32] = BusMuxOut; Zhighout = 0;
        Zlowout  = 1; #1; z[31:0]  = BusMuxOut; Zlowout  = 0;
    endtask

    task automatic run_alu(input logic [4:0] op, input logic inc, input logic [31:0] a,
                           input logic [31:0] b, output logic [63:0] z);
        load_mdr(a);
        MDRout = 1; Yin = 1;
        step();
        load_mdr(b);
        MDRout = 1; opcode = op; IncPC = inc; Zin = 1;
        step();
        read_z(z);
    endtask

    // Reference ALU: straight arithmetic, shifts and rotates done one bit at a time.
    function automatic logic [63:0] alu_ref(input logic [4:0] op, input logic inc,
                                            input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        longint      sa, sb, p, q, m;
        int          s;
        s  = int'(b % 32);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = a;
        if (inc) return {32'd0, b + 32'd1};
        case (op)
            5'd3:  return {32'd0, a + b};
            5'd4:  return {32'd0, a - b};
            5'd5:  return {32'd0, a & b};
            5'd6:  return {32'd0, a | b};
            5'd7:  begin repeat (s) r = r / 2;                return {32'd0, r}; end
            5'd8:  begin repeat (s) r = {r[31], r[31:1]};     return {32'd0, r}; end
            5'd9:  begin repeat (s) r = r * 2;                return {32'd0, r}; end
            5'd10: begin repeat (s) r = {r[0], r[31:1]};      return {32'd0, r}; end
            5'd11: begin repeat (s) r = {r[30:0], r[31]};     return {32'd0, r}; end
            5'd16: return {32'd0, 32'd0 - b};
            5'd17: return {32'd0, ~b};
            5'd14: begin
                if (!MD) return 64'd0;
                p = sa * sb;
                return p;
            end
            5'd15: begin
                if (!MD || b == 32'd0) return 64'd0;
                q = sa / sb;
                m = sa % sb;
                return {m[31:0], q[31:0]};
            end
            default: return 64'd0;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        logic [63:0] z;
        logic [31:0] m [16];
        logic [4:0]  ops [13];

        vt[0]  = '{5'd3,  1'b0, 32'hFFFF_FFFF, 32'h1,         64'h0, 64'h0};
        vt[1]  = '{5'd3,  1'b0, 32'h5,         32'h7,         64'hC, 64'hC};
        vt[2]  = '{5'd4,  1'b0, 32'h5,         32'h7,         64'hFFFF_FFFE, 64'hFFFF_FFFE};
        vt[3]  = '{5'd5,  1'b0, 32'hF0F0_1234, 32'h0FF0_FF00, 64'h00F0_1200, 64'h00F0_1200};
        vt[4]  = '{5'd6,  1'b0, 32'hF000_0000, 32'h0000_000F, 64'hF000_000F, 64'hF000_000F};
        vt[5]  = '{5'd7,  1'b0, 32'h8000_0000, 32'h4,         64'h0800_0000, 64'h0800_0000};
        vt[6]  = '{5'd7,  1'b0, 32'h10,        32'h21,        64'h8, 64'h8};
        vt[7]  = '{5'd8,  1'b0, 32'h8000_0000, 32'h4,         64'hF800_0000, 64'hF800_0000};
        vt[8]  = '{5'd9,  1'b0, 32'h1,         32'h1F,        64'h8000_0000, 64'h8000_0000};
        vt[9]  = '{5'd10, 1'b0, 32'h1,         32'h1,         64'h8000_0000, 64'h8000_0000};
        vt[10] = '{5'd11, 1'b0, 32'h8000_0001, 32'h4,         64'h18, 64'h18};
        vt[11] = '{5'd16, 1'b0, 32'h0,         32'h1,         64'hFFFF_FFFF, 64'hFFFF_FFFF};
        vt[12] = '{5'd17, 1'b0, 32'h0,         32'h0F0F_0F0F, 64'hF0F0_F0F0, 64'hF0F0_F0F0};
        vt[13] = '{5'd3,  1'b1, 32'h64,        32'h29,        64'h2A, 64'h2A};
        vt[14] = '{5'd31, 1'b0, 32'h1234,      32'h5678,      64'h0, 64'h0};
        vt[15] = '{5'd14, 1'b0, 32'hFFFF_FFFD, 32'h7,         64'h0, 64'hFFFF_FFFF_FFFF_FFEB};
        vt[16] = '{5'd15, 1'b0, 32'hFFFF_FFF9, 32'h2,         64'h0, 64'hFFFF_FFFF_FFFF_FFFD};
        vt[17] = '{5'd15, 1'b0, 32'h7,         32'h0,         64'h0, 64'h0};
        vt[18] = '{5'd10, 1'b0, 32'h1234_5678, 32'h0,         64'h1234_5678, 64'h1234_5678};
        ops = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd14, 5'd15, 5'd16, 5'd17};

        clr_strobes();
        Mdatain = '0;
        clear = 1;
        #2;
        chk("reset_bus_idle", BusMuxOut, 0);
        read_z(z);
        chk("reset_z", z, 0);
        Cout = 1; #1; chk("reset_c", BusMuxOut, 0); Cout = 0;
        @(negedge Clock);
        clear = 0;
        step();

        // Clear mid-cycle zeroes loaded registers before any edge.
        load_mdr(32'd5);
        MDRout = 1; rin[1] = 1; PCin = 1; IncPC = 1; Zin = 1;
        step();
        read_r(1, v); chk("preclear_r1", v, 5);
        clear = 1; #1;
        read_r(1, v); chk("clear_r1", v, 0);
        PCout = 1; #1; chk("clear_pc", BusMuxOut, 0); PCout = 0;
        read_z(z); chk("clear_z", z, 0);
        MDRout = 1; #1; chk("clear_mdr", BusMuxOut, 0); MDRout = 0;
        Mdatain = 32'h55; Read = 1; MDRin = 1;
        step();
        MDRout = 1; #1; chk("clear_dominates_load", BusMuxOut, 0); MDRout = 0;
        clear = 0;
        step();

        // MDR to R2 transfer.
        load_mdr(32'h8);
        MDRout = 1; rin[2] = 1; #1;
        chk("mdr_xfer_bus", BusMuxOut, 32'h8);
        step();
        read_r(2, v); chk("r2_from_mdr", v, 32'h8);

        // PC increment through Z.
        PCout = 1; MARin = 1; IncPC = 1; Zin = 1;
        step();
        MARout = 1; #1; chk("mar_pc0", BusMuxOut, 0); MARout = 0;
        read_z(z); chk("z_pc_plus1", z, 64'h1);
        Zlowout = 1; PCin = 1;
        step();
        PCout = 1; #1; chk("pc_incremented", BusMuxOut, 1); PCout = 0;

        // Drive and load the same register: Z captures the pre-edge bus plus one.
        Zlowout = 1; IncPC = 1; Zin = 1;
        step();
        read_z(z); chk("z_self_update", z, 64'h2);

        // IR load and C sign extension.
        load_mdr(32'h1891_8000);
        MDRout = 1; IRin = 1;
        step();
        IRout = 1; #1; chk("ir_load", BusMuxOut, 32'h1891_8000); IRout = 0;
        Cin = 1;
        step();
        Cout = 1; #1; chk("c_pos", BusMuxOut, 32'h0001_8000); Cout = 0;
        load_mdr(32'h0004_0001);
        MDRout = 1; IRin = 1;
        step();
        Cin = 1;
        step();
        Cout = 1; #1; chk("c_neg", BusMuxOut, 32'hFFFC_0001); Cout = 0;

        // Add sequence R1 = R2 + R3.
        load_mdr(32'h9);
        MDRout = 1; rin[3] = 1;
        step();
        rout[2] = 1; Yin = 1;
        step();
        rout[3] = 1; opcode = 5'b00011; Zin = 1;
        step();
        Zlowout = 1; rin[1] = 1;
        step();
        read_r(1, v); chk("add_r1", v, 32'h11);

        // MDR from bus when Read is low.
        Mdatain = 32'hDEAD; rout[1] = 1; MDRin = 1;
        step();
        MDRout = 1; #1; chk("mdr_from_bus", BusMuxOut, 32'h11); MDRout = 0;

        // Special registers and bus priority.
        load_mdr(32'hA); MDRout = 1; rin[0] = 1; HIin = 1; step();
        load_mdr(32'hB); MDRout = 1; PCin = 1; LOin = 1; Inportin = 1; step();
        load_mdr(32'hC); MDRout = 1; rin[9] = 1; MARin = 1; step();
        HIout = 1; #1; chk("hi", BusMuxOut, 32'hA); HIout = 0;
        LOout = 1; #1; chk("lo", BusMuxOut, 32'hB); LOout = 0;
        Inportout = 1; #1; chk("inport", BusMuxOut, 32'hB); Inportout = 0;
        MARout = 1; #1; chk("mar", BusMuxOut, 32'hC); MARout = 0;
        rout[0] = 1; PCout = 1; #1; chk("prio_r0_pc", BusMuxOut, 32'hA); clr_strobes();
        rout[3] = 1; rout[9] = 1; #1; chk("prio_r3_r9", BusMuxOut, 32'h9); clr_strobes();
        LOout = 1; Cout = 1; MARout = 1; #1; chk("prio_lo_c", BusMuxOut, 32'hB); clr_strobes();
        MARout = 1; MDRout = 1; #1; chk("prio_mar_mdr", BusMuxOut, 32'hC); clr_strobes();
        #1; chk("bus_idle", BusMuxOut, 0);

        for (int i = 0; i < 19; i++) begin
            run_alu(vt[i].op, vt[i].inc, vt[i].a, vt[i].b, z);
            chk($sformatf("vec%0d_op%0d", i, vt[i].op), z, MD ? vt[i].z_md : vt[i].z_base);
        end

        for (int i = 0; i < 250; i++) begin
            logic [4:0]  op;
            logic        inc;
            logic [31:0] a, b;
            op  = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : ops[$urandom_range(0, 12)];
            inc = ($urandom_range(0, 9) == 0);
            a   = $urandom;
            b   = ($urandom_range(0, 5) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'h3;
            run_alu(op, inc, a, b, z);
            chk($sformatf("rand_alu op%0d a%h b%h", op, a, b), z, alu_ref(op, inc, a, b));
        end

        for (int i = 0; i < 16; i++) begin
            m[i] = $urandom;
            load_mdr(m[i]);
            MDRout = 1; rin[i] = 1;
            step();
        end
        for (int i = 0; i < 120; i++) begin
            int j, k;
            j = $urandom_range(0, 15);
            k = $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 0) begin
                m[k] = $urandom;
                load_mdr(m[k]);
                MDRout = 1; rin[k] = 1;
            end
            else begin
                rout[j] = 1; rin[k] = 1;
                m[k] = m[j];
            end
            step();
            j = $urandom_range(0, 15);
            read_r(j, v);
            chk($sformatf("rand_rf r%0d", j), v, m[j]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
